// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A = CPU LSU, B = debug/DMA) arbiter and access
// sequencer for the shared data SRAM. Each granted access walks
// IDLE -> GRANT -> ACCESS (ACCESS_CYCLES) -> RESP -> IDLE and ends with a
// one-cycle ack to the winner.
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int D_ADDR_WIDTH  = 7,
  parameter int ACCESS_CYCLES = 1,
  parameter int FIXED_PRIO    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [D_ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_ack,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [D_ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_ack,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_oe,
  output logic [D_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    owner
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCESS, S_RESP} state_e;

  // Counter counts down to 0 on the final ACCESS cycle.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [D_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    owner_q;
  logic                    prio_q;    // port that wins the next tie (0 = A)
  logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
  logic                    win_b;
  logic                    start;
  logic                    last_acc;

  assign start    = (state_q == S_IDLE) && (a_req || b_req);
  assign last_acc = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  // Winner select: a lone requester wins; ties go to A or to the round-robin pointer.
  always_comb begin
    win_b = b_req;
    if (a_req && b_req) win_b = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
  end

  // State register and access-length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic for the fixed-length access window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (a_req || b_req) state_d = S_GRANT;
      S_GRANT: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_LOAD;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Latch the winning request at grant time and capture read data on the last ACCESS edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (start) begin
        we_q    <= win_b ? b_we    : a_we;
        addr_q  <= win_b ? b_addr  : a_addr;
        wdata_q <= win_b ? b_wdata : a_wdata;
        owner_q <= win_b;
        prio_q  <= ~win_b;
      end
      if (last_acc && !we_q) begin
        if (owner_q) b_rdata_q <= mem_rdata;
        else         a_rdata_q <= mem_rdata;
      end
    end
  end

  // SRAM strobes only in ACCESS; address/data parked at 0 while idle.
  assign mem_cs    = (state_q == S_ACCESS);
  assign mem_we    = mem_cs &  we_q;
  assign mem_oe    = mem_cs & ~we_q;
  assign mem_addr  = (state_q == S_IDLE) ? '0 : addr_q;
  assign mem_wdata = (state_q == S_IDLE) ? '0 : wdata_q;
  assign a_ack     = (state_q == S_RESP) & ~owner_q;
  assign b_ack     = (state_q == S_RESP) &  owner_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (default, fixed priority, 3-cycle
// access) each with a small SRAM model; acks are checked against a scoreboard.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_req [3], a_we [3], b_req [3], b_we [3];
  logic [6:0] a_addr [3], b_addr [3], mem_addr [3];
  logic [7:0] a_wdata [3], b_wdata [3], a_rdata [3], b_rdata [3];
  logic [7:0] mem_wdata [3], mem_rdata [3];
  logic       a_ack [3], b_ack [3], mem_cs [3], mem_we [3], mem_oe [3];
  logic       busy [3], owner [3];

  dmem_arbiter u0 (.clk(clk), .reset(rst_n),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
    .mem_cs(mem_cs[0]), .mem_we(mem_we[0]), .mem_oe(mem_oe[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0]));

  dmem_arbiter #(.FIXED_PRIO(1)) u1 (.clk(clk), .reset(rst_n),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
    .mem_cs(mem_cs[1]), .mem_we(mem_we[1]), .mem_oe(mem_oe[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1]));

  dmem_arbiter #(.ACCESS_CYCLES(3)) u2 (.clk(clk), .reset(rst_n),
    .a_req(a_req[2]), .a_we(a_we[2]), .a_addr(a_addr[2]), .a_wdata(a_wdata[2]),
    .a_ack(a_ack[2]), .a_rdata(a_rdata[2]),
    .b_req(b_req[2]), .b_we(b_we[2]), .b_addr(b_addr[2]), .b_wdata(b_wdata[2]),
    .b_ack(b_ack[2]), .b_rdata(b_rdata[2]),
    .mem_cs(mem_cs[2]), .mem_we(mem_we[2]), .mem_oe(mem_oe[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]), .busy(busy[2]), .owner(owner[2]));

  // SRAM models; initial content of word i is i ^ 0x3C. Instance 2 returns a
  // value that changes every cs-high cycle so the capture cycle is visible.
  logic [7:0] mem [3][128];
  logic       mem_init = 1'b0;
  logic [7:0] cs_run = 8'd0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < 128; i++) mem[d][i] <= 8'(i) ^ 8'h3C;
      mem_init <= 1'b1;
    end else begin
      for (int d = 0; d < 3; d++)
        if (mem_cs[d] && mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
    end
    cs_run <= mem_cs[2] ? cs_run + 8'd1 : 8'd0;
  end
  assign mem_rdata[0] = mem[0][mem_addr[0]];
  assign mem_rdata[1] = mem[1][mem_addr[1]];
  assign mem_rdata[2] = 8'hA0 + cs_run;

  typedef struct { int d; int p; logic [7:0] rd; } exp_t;
  exp_t       sbq [$];
  logic [7:0] last_rd [3][2];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cs_cyc [3], we_cyc [3], oe_cyc [3];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: strobe counts, invariants, and scoreboard pop on every ack.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      cs_cyc[d] += int'(mem_cs[d]);
      we_cyc[d] += int'(mem_we[d]);
      oe_cyc[d] += int'(mem_oe[d]);
      if (mem_cs[d]) chk("cs_busy", 32'(busy[d]), 32'd1);
      if (a_ack[d] || b_ack[d]) begin
        chk("ack_excl", 32'(a_ack[d] & b_ack[d]), 32'd0);
        n_cmp++;
        assert (sbq.size() > 0) else begin
          n_err++;
          $error("FAIL ack_unexpected dut=%0d a_ack=%0b b_ack=%0b expected=none", d, a_ack[d], b_ack[d]);
        end
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_dut", d, e.d);
          chk("ack_port", 32'(b_ack[d]), e.p);
          chk("ack_rdata", b_ack[d] ? 32'(b_rdata[d]) : 32'(a_rdata[d]), 32'(e.rd));
        end
      end
    end
  end

  task automatic drive(int d, int p, logic we, logic [6:0] addr, logic [7:0] wd);
    if (p == 0) begin a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd; end
    else        begin b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd; end
  endtask

  task automatic drop(int d, int p);
    if (p == 0) a_req[d] = 1'b0; else b_req[d] = 1'b0;
  endtask

  // Push the expected completion; writes leave the port's rdata unchanged.
  task automatic expect_x(int d, int p, logic we, logic [7:0] rd);
    exp_t e;
    if (!we) last_rd[d][p] = rd;
    e.d = d; e.p = p; e.rd = last_rd[d][p];
    sbq.push_back(e);
  endtask

  // Wait (bounded) for the next ack of instance d; check latency and port.
  task automatic wait_ack(string tag, int d, int p, int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(a_ack[d] || b_ack[d]) && lat < 40);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ackport"}, 32'(b_ack[d]), p);
    chk({tag, "_owner"}, 32'(owner[d]), p);
  endtask

  task automatic clr_cnt(int d);
    cs_cyc[d] = 0; we_cyc[d] = 0; oe_cyc[d] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin last_rd[d][0] = 8'h00; last_rd[d][1] = 8'h00; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      a_req[d] = 0; a_we[d] = 0; a_addr[d] = '0; a_wdata[d] = '0;
      b_req[d] = 0; b_we[d] = 0; b_addr[d] = '0; b_wdata[d] = '0;
      last_rd[d][0] = 8'h00; last_rd[d][1] = 8'h00;
      cs_cyc[d] = 0; we_cyc[d] = 0; oe_cyc[d] = 0;
    end
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(mem_cs[0]), 0);
    chk("rst_we", 32'(mem_we[0]), 0);
    chk("rst_oe", 32'(mem_oe[0]), 0);
    chk("rst_addr", 32'(mem_addr[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_owner", 32'(owner[0]), 0);
    chk("rst_ack", 32'({a_ack[0], b_ack[0]}), 0);
    chk("rst_rdata", 32'({a_rdata[0], b_rdata[0]}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: A writes 0x5A to 0x10, then reads it back
    clr_cnt(0);
    drive(0, 0, 1'b1, 7'h10, 8'h5A); expect_x(0, 0, 1'b1, 8'h00);
    wait_ack("t1w", 0, 0, 3); drop(0, 0);
    chk("t1w_cs", cs_cyc[0], 1); chk("t1w_we", we_cyc[0], 1); chk("t1w_oe", oe_cyc[0], 0);
    @(negedge clk);
    chk("t1_mem", 32'(mem[0][7'h10]), 32'h5A);
    chk("t1_idle_addr", 32'(mem_addr[0]), 0);
    chk("t1_idle_busy", 32'(busy[0]), 0);
    clr_cnt(0);
    drive(0, 0, 1'b0, 7'h10, 8'h00); expect_x(0, 0, 1'b0, 8'h5A);
    wait_ack("t1r", 0, 0, 3); drop(0, 0);
    chk("t1r_we", we_cyc[0], 0); chk("t1r_oe", oe_cyc[0], 1);
    @(negedge clk);

    // 2: round-robin with both requests held for 4 transactions
    do_reset();
    drive(0, 0, 1'b1, 7'h20, 8'h33);
    drive(0, 1, 1'b0, 7'h10, 8'h00);
    expect_x(0, 0, 1'b1, 8'h00); expect_x(0, 1, 1'b0, 8'h5A);
    expect_x(0, 0, 1'b1, 8'h00); expect_x(0, 1, 1'b0, 8'h5A);
    wait_ack("t2_1", 0, 0, 3);
    wait_ack("t2_2", 0, 1, 4);
    wait_ack("t2_3", 0, 0, 4);
    wait_ack("t2_4", 0, 1, 4);
    drop(0, 0); drop(0, 1);
    @(negedge clk);
    chk("t2_mem", 32'(mem[0][7'h20]), 32'h33);

    // 3: fixed priority, A held keeps winning; B gets in once A drops
    drive(1, 0, 1'b0, 7'h05, 8'h00);
    drive(1, 1, 1'b0, 7'h06, 8'h00);
    expect_x(1, 0, 1'b0, 8'h39); expect_x(1, 0, 1'b0, 8'h39); expect_x(1, 0, 1'b0, 8'h39);
    expect_x(1, 1, 1'b0, 8'h3A);
    wait_ack("t3_1", 1, 0, 3);
    wait_ack("t3_2", 1, 0, 4);
    wait_ack("t3_3", 1, 0, 4);
    drop(1, 0);
    wait_ack("t3_4", 1, 1, 4);
    drop(1, 1);
    @(negedge clk);

    // 4: three-cycle access, read 0x7F; data from the last ACCESS cycle
    clr_cnt(2);
    drive(2, 0, 1'b0, 7'h7F, 8'h00); expect_x(2, 0, 1'b0, 8'hA2);
    wait_ack("t4", 2, 0, 5); drop(2, 0);
    chk("t4_cs", cs_cyc[2], 3); chk("t4_oe", oe_cyc[2], 3);
    @(negedge clk);

    // 5: reset in the middle of a B write
    drive(0, 1, 1'b1, 7'h30, 8'h44);
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_access", 32'(mem_cs[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_cs", 32'(mem_cs[0]), 0);
    chk("t5_we", 32'(mem_we[0]), 0);
    chk("t5_busy", 32'(busy[0]), 0);
    drop(0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin last_rd[d][0] = 8'h00; last_rd[d][1] = 8'h00; end
    chk("t5_nowrite", 32'(mem[0][7'h30]), 32'h0C);
    drive(0, 0, 1'b0, 7'h10, 8'h00);
    drive(0, 1, 1'b0, 7'h20, 8'h00);
    expect_x(0, 0, 1'b0, 8'h5A); expect_x(0, 1, 1'b0, 8'h33);
    wait_ack("t5_tie", 0, 0, 3); drop(0, 0);
    wait_ack("t5_next", 0, 1, 4); drop(0, 1);
    @(negedge clk);

    // 6: B drops req during GRANT; write still completes with a single ack
    drive(0, 1, 1'b1, 7'h00, 8'h77); expect_x(0, 1, 1'b1, 8'h00);
    @(negedge clk);
    chk("t6_grant", 32'(busy[0]), 1);
    drop(0, 1);
    wait_ack("t6", 0, 1, 2);
    n = 0;
    repeat (5) begin @(negedge clk); n += int'(b_ack[0]); end
    chk("t6_single", n, 0);
    chk("t6_mem", 32'(mem[0][7'h00]), 32'h77);
    chk("t6_sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
